// File: rtl/key_schedule_engine_if.sv
// Start/status handshake and round-key read bus
// for the AES key schedule engine.
interface key_schedule_engine_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy;
  logic         done;
  logic         key_ready;
  logic         err;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_valid;

  modport master (
    output start, key_len, key_in, rk_idx,
    input  busy, done, key_ready, err,
    input  rk_out, rk_valid
  );

  modport slave (
    input  start, key_len, key_in, rk_idx,
    output busy, done, key_ready, err,
    output rk_out, rk_valid
  );
endinterface

// File: rtl/key_schedule_engine.sv
// AES-128/192/256 key expansion, one word per cycle,
// into a register file read back as 128-bit round keys.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [7:0] m
  );
    logic [7:0] r, s;
    r = '0;
    s = x;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) r = r ^ s;
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  logic [7:0] p, b;

  // GF(2^8) inverse as a^254, then the affine map
  always_comb begin
    p = a;
    b = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      b = gmul(b, p);
    end
    y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
          ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
          ^ 8'h63;
  end
endmodule

module key_schedule_engine #(
  parameter int MAX_KEY_BITS = 256
) (
  input logic clk,
  input logic rst,
  key_schedule_engine_if.slave bus
);
  localparam int MAX_NK = MAX_KEY_BITS / 32;
  localparam int DEPTH = 4 * (MAX_NK + 7);
  localparam logic [3:0] NK_LIM = 4'(MAX_NK);

  typedef enum logic [1:0] {
    IDLE, EXPAND, DONE
  } state_t;

  state_t      state, nstate;
  logic [3:0]  nk, nr, nk_sel, nr_sel;
  logic [5:0]  i, total;
  logic [2:0]  md;
  logic [7:0]  rcon;
  logic        kr, err_q;
  logic        legal, acc, rej, last, wr;
  logic [31:0] win [MAX_NK];
  logic [31:0] rf [DEPTH];
  logic [31:0] prev, oldest, rot;
  logic [31:0] sub_in, sub_out, temp, new_w;

  function automatic logic [31:0] kword(
    input logic [255:0] k,
    input int n
  );
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 8; j++)
      if (j == n) r = k[255-32*j -: 32];
    return r;
  endfunction

  always_comb begin
    nk_sel = 4'd4;
    nr_sel = 4'd10;
    unique case (1'b1)
      bus.key_len == 2'd1: begin
        nk_sel = 4'd6;
        nr_sel = 4'd12;
      end
      bus.key_len == 2'd2: begin
        nk_sel = 4'd8;
        nr_sel = 4'd14;
      end
      default: ;
    endcase
  end

  assign legal = (bus.key_len != 2'd3)
              && (nk_sel <= NK_LIM);
  assign acc   = (state == IDLE) && bus.start && legal;
  assign rej   = (state == IDLE) && bus.start && !legal;
  assign total = {nr + 4'd1, 2'b00};
  assign last  = (i == total);
  assign wr    = (state == EXPAND) && !last;

  // win[0] is w[i-1]; w[i-Nk] sits at win[Nk-1]
  always_comb begin
    oldest = '0;
    for (int j = 0; j < MAX_NK; j++)
      if (j == int'(nk) - 1) oldest = win[j];
  end

  assign prev   = win[0];
  assign rot    = {prev[23:0], prev[31:24]};
  assign sub_in = (md == 3'd0) ? rot : prev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox u_sbox (
      .a(sub_in[8*g +: 8]),
      .y(sub_out[8*g +: 8])
    );
  end

  always_comb begin
    temp = prev;
    unique case (1'b1)
      md == 3'd0:
        temp = sub_out ^ {rcon, 24'h0};
      nk == 4'd8 && md == 3'd4:
        temp = sub_out;
      default: ;
    endcase
  end

  assign new_w = oldest ^ temp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (acc) nstate = EXPAND;
      EXPAND:  if (last) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == EXPAND);
    bus.done = (state == DONE);
  end

  assign bus.err       = err_q;
  assign bus.key_ready = kr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i     <= '0;
      md    <= '0;
      rcon  <= 8'h01;
      nk    <= 4'd4;
      nr    <= 4'd10;
      kr    <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= rej;
      if (acc) begin
        nk   <= nk_sel;
        nr   <= nr_sel;
        i    <= {2'b00, nk_sel};
        md   <= '0;
        rcon <= 8'h01;
        kr   <= 1'b0;
      end else if (wr) begin
        i  <= i + 6'd1;
        md <= (md == 3'(nk - 4'd1)) ? 3'd0 : md + 3'd1;
        if (md == 3'd0)
          rcon <= {rcon[6:0], 1'b0}
                ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      if (state == EXPAND && last) kr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      for (int j = 0; j < MAX_NK; j++) begin
        win[j] <= kword(bus.key_in, int'(nk_sel) - 1 - j);
        if (4'(j) < nk_sel) rf[j] <= kword(bus.key_in, j);
      end
    end else if (wr) begin
      win[0] <= new_w;
      for (int j = 1; j < MAX_NK; j++)
        win[j] <= win[j-1];
      rf[i] <= new_w;
    end
  end

  always_comb begin
    bus.rk_out = '0;
    if (bus.rk_idx <= nr)
      for (int k = 0; k < 4; k++)
        bus.rk_out[127-32*k -: 32] =
          rf[{bus.rk_idx, 2'b00} + 6'(k)];
  end

  assign bus.rk_valid = kr && (bus.rk_idx <= nr);
endmodule

// File: tb/tb_key_schedule_engine.sv
// Randomized and FIPS-197 vector bench for the key
// schedule engine against a plain-arithmetic model.
module tb_key_schedule_engine;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  key_schedule_engine_if bus ();
  key_schedule_engine_if bus128 ();

  key_schedule_engine #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  key_schedule_engine #(.MAX_KEY_BITS(128)) dut128 (
    .clk(clk), .rst(rst), .bus(bus128)
  );

  always #20 clk = ~clk;

  localparam logic [255:0] K128 =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 =
    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
     64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] ex [256];
    int lg [256];
    logic [7:0] x, b;
    x = 8'h01;
    for (int k = 0; k < 255; k++) begin
      ex[k] = x;
      lg[x] = k;
      x = x ^ xt(x);
    end
    for (int a = 0; a < 256; a++) begin
      b = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
      sb[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]],
            sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [127:0] model_rk(
    input logic [1:0] len,
    input logic [255:0] key,
    input int r
  );
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    int nk, nr;
    nk = 4 + 2 * int'(len);
    nr = 10 + 2 * int'(len);
    rc = 8'h01;
    for (int n = 0; n < 60; n++) w[n] = '0;
    for (int n = 0; n < nk; n++) w[n] = key[255-32*n -: 32];
    for (int n = nk; n < 4 * (nr + 1); n++) begin
      t = w[n-1];
      if (n % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && n % 8 == 4) begin
        t = subw(t);
      end
      w[n] = w[n-nk] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic start_run(
    input logic [1:0] len,
    input logic [255:0] key
  );
    bus.start   = 1'b1;
    bus.key_len = len;
    bus.key_in  = key;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.key_ready, bus.err,
         bus.rk_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 00000",
        {bus.busy, bus.done, bus.key_ready, bus.err,
         bus.rk_valid});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus128.busy, bus128.key_ready, bus128.rk_valid,
         bus.busy, bus.rk_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_release: got %b want 00000",
        {bus128.busy, bus128.key_ready, bus128.rk_valid,
         bus.busy, bus.rk_valid});
    end
  endtask

  task automatic test_fips(
    input string tag,
    input logic [1:0] len,
    input logic [255:0] key,
    input int ecyc,
    input int ia, input logic [127:0] ea,
    input int ib, input logic [127:0] eb
  );
    int c, nr;
    logic [127:0] e;
    nr = 10 + 2 * int'(len);
    start_run(len, key);
    wait_done(c);
    n_cmp++;
    if (c !== ecyc) begin
      n_bad++;
      $display("FAIL %s_cycles: got %0d want %0d", tag, c, ecyc);
    end
    n_cmp++;
    if (bus.key_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_key_ready: got %b want 1",
        tag, bus.key_ready);
    end
    for (int r = 0; r <= nr; r++) begin
      bus.rk_idx = 4'(r);
      #1;
      e = model_rk(len, key, r);
      n_cmp++;
      if (bus.rk_out !== e || bus.rk_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_rk%0d: got %h/%b want %h/1",
          tag, r, bus.rk_out, bus.rk_valid, e);
      end
    end
    bus.rk_idx = 4'(ia);
    #1;
    n_cmp++;
    if (bus.rk_out !== ea) begin
      n_bad++;
      $display("FAIL %s_vec%0d: got %h want %h",
        tag, ia, bus.rk_out, ea);
    end
    bus.rk_idx = 4'(ib);
    #1;
    n_cmp++;
    if (bus.rk_out !== eb) begin
      n_bad++;
      $display("FAIL %s_vec%0d: got %h want %h",
        tag, ib, bus.rk_out, eb);
    end
    bus.rk_idx = 4'(nr + 1);
    #1;
    n_cmp++;
    if (bus.rk_valid !== 1'b0 || bus.rk_out !== '0) begin
      n_bad++;
      $display("FAIL %s_beyond_nr: got %b/%h want 0/0",
        tag, bus.rk_valid, bus.rk_out);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.key_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_done_pulse: got %b/%b want 0/1",
        tag, bus.done, bus.key_ready);
    end
  endtask

  task automatic test_busy_start();
    int c;
    logic [127:0] e;
    start_run(2'd0, K128);
    repeat (9) @(negedge clk);
    bus.start   = 1'b1;
    bus.key_len = 2'd2;
    bus.key_in  = {8{$urandom()}};
    @(negedge clk);
    bus.start   = 1'b0;
    wait_done(c);
    n_cmp++;
    if (c < 0 || c + 10 !== 41) begin
      n_bad++;
      $display("FAIL busy_start_cycles: got %0d want 41",
        c < 0 ? c : c + 10);
    end
    for (int r = 0; r <= 10; r++) begin
      bus.rk_idx = 4'(r);
      #1;
      e = model_rk(2'd0, K128, r);
      n_cmp++;
      if (bus.rk_out !== e) begin
        n_bad++;
        $display("FAIL busy_start_rk%0d: got %h want %h",
          r, bus.rk_out, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    logic [127:0] e;
    bus.start   = 1'b1;
    bus.key_len = 2'd3;
    bus.key_in  = {8{$urandom()}};
    @(negedge clk);
    bus.start   = 1'b0;
    n_cmp++;
    if ({bus.err, bus.busy, bus.key_ready} !== 3'b101) begin
      n_bad++;
      $display("FAIL illegal_err: got %b want 101",
        {bus.err, bus.busy, bus.key_ready});
    end
    bus.rk_idx = 4'd1;
    #1;
    e = model_rk(2'd0, K128, 1);
    n_cmp++;
    if (bus.rk_out !== e || bus.rk_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_keep: got %h want %h",
        bus.rk_out, e);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_err_drop: got %b/%b want 0/0",
        bus.err, bus.busy);
    end
    bus128.start   = 1'b1;
    bus128.key_len = 2'd2;
    bus128.key_in  = K256;
    @(negedge clk);
    bus128.start   = 1'b0;
    n_cmp++;
    if ({bus128.err, bus128.busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL max128_err: got %b want 10",
        {bus128.err, bus128.busy});
    end
    bus128.start   = 1'b1;
    bus128.key_len = 2'd0;
    bus128.key_in  = K256;
    @(negedge clk);
    bus128.start   = 1'b0;
    repeat (41) @(negedge clk);
    bus128.rk_idx = 4'd10;
    #1;
    e = model_rk(2'd0, K256, 10);
    n_cmp++;
    if (bus128.done !== 1'b1 || bus128.rk_out !== e) begin
      n_bad++;
      $display("FAIL max128_aes128: got %b/%h want 1/%h",
        bus128.done, bus128.rk_out, e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c, nr, ecyc;
    logic [1:0] len;
    logic [255:0] key;
    logic [127:0] e;
    for (int t = 0; t < 6; t++) begin
      len = 2'($urandom_range(0, 2));
      key = {8{$urandom()}};
      for (int q = 0; q < 8; q++) key[32*q +: 32] = $urandom();
      nr   = 10 + 2 * int'(len);
      ecyc = 4 * (nr + 1) - (4 + 2 * int'(len)) + 1;
      start_run(len, key);
      wait_done(c);
      n_cmp++;
      if (c !== ecyc) begin
        n_bad++;
        $display("FAIL b2b%0d_cycles: got %0d want %0d",
          t, c, ecyc);
      end
      for (int r = 0; r <= nr; r++) begin
        bus.rk_idx = 4'(r);
        #1;
        e = model_rk(len, key, r);
        n_cmp++;
        if (bus.rk_out !== e || bus.rk_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b%0d_rk%0d: got %h want %h",
            t, r, bus.rk_out, e);
        end
      end
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b%0d_idle: got %b/%b want 0/0",
          t, bus.done, bus.busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c;
    logic [127:0] e;
    start_run(2'd2, K256);
    repeat (19) @(negedge clk);
    bus.rk_idx = 4'd0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.key_ready, bus.err,
         bus.rk_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %b want 00000",
        {bus.busy, bus.done, bus.key_ready, bus.err,
         bus.rk_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_run(2'd0, K128);
    wait_done(c);
    n_cmp++;
    if (c !== 41) begin
      n_bad++;
      $display("FAIL reset_mid_cycles: got %0d want 41", c);
    end
    for (int r = 0; r <= 10; r++) begin
      bus.rk_idx = 4'(r);
      #1;
      e = model_rk(2'd0, K128, r);
      n_cmp++;
      if (bus.rk_out !== e) begin
        n_bad++;
        $display("FAIL reset_mid_rk%0d: got %h want %h",
          r, bus.rk_out, e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.key_len    = 2'd0;
    bus.key_in     = '0;
    bus.rk_idx     = 4'd0;
    bus128.start   = 1'b0;
    bus128.key_len = 2'd0;
    bus128.key_in  = '0;
    bus128.rk_idx  = 4'd0;
    build_sbox();
    test_reset();
    test_fips("aes128", 2'd0, K128, 41,
      1,  128'ha0fafe1788542cb123a339392a6c7605,
      10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    test_fips("aes192", 2'd1, K192, 47,
      0,  128'h8e73b0f7da0e6452c810f32b809079e5,
      12, 128'he98ba06f448c773c8ecc720401002202);
    test_fips("aes256", 2'd2, K256, 53,
      1,  128'h1f352c073b6108d72d9810a30914dff4,
      14, 128'hfe4890d1e6188d0b046df344706c631e);
    test_busy_start();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end
endmodule
